// File: rtl/disp_pkg.sv
// Shared constants and types for the BCD display sequencer.
package disp_pkg;

  localparam int          NDIG       = 7;
  localparam int          DATA_W     = 24;
  localparam logic [23:0] MAX_VAL    = 24'd9999999;
  localparam logic [3:0]  BLANK_CODE = 4'hF;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3_stage.sv
// Double-dabble adjust: every BCD nibble >= 5 gets +3 before the next shift.
module bcd_add3_stage
  import disp_pkg::*;
#(
  parameter int NDIG = 7
) (
  input  logic [4*NDIG-1:0] bcd_i,
  output logic [4*NDIG-1:0] bcd_o
);

  digit_t nib;

  always_comb begin
    bcd_o = bcd_i;
    nib   = '0;
    for (int i = 0; i < NDIG; i++) begin
      nib = bcd_i[4*i +: 4];
      if (nib >= 4'd5) begin
        bcd_o[4*i +: 4] = nib + 4'd3;
      end
    end
  end

endmodule

// File: rtl/disp_bcd_ctrl.sv
// Binary-to-BCD sequencer feeding the 7-digit seven-segment decoder bank,
// with leading-zero blanking, overflow blanking and periodic auto-refresh.
module disp_bcd_ctrl
  import disp_pkg::*;
#(
  parameter int                DATA_W      = disp_pkg::DATA_W,
  parameter int                NDIG        = disp_pkg::NDIG,
  parameter logic [DATA_W-1:0] MAX_VAL     = disp_pkg::MAX_VAL,
  parameter logic [3:0]        BLANK_CODE  = disp_pkg::BLANK_CODE,
  parameter int                REFRESH_DIV = 50000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  input  logic              lzb,
  input  logic              auto_en,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              upd,
  output logic [3:0]        dig0,
  output logic [3:0]        dig1,
  output logic [3:0]        dig2,
  output logic [3:0]        dig3,
  output logic [3:0]        dig4,
  output logic [3:0]        dig5,
  output logic [3:0]        dig6
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam int               BCD_W    = 4 * NDIG;

  state_e             state_q, state_d;
  logic [4:0]         iter_q, iter_d;
  logic               lzb_q, lzb_d;
  logic               ovfn_q, ovfn_d;
  logic               ovf_q;
  logic               upd_q;
  logic [CNT_W-1:0]   refcnt_q;
  logic [DATA_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
  digit_t             dig_q   [NDIG];
  digit_t             dig_new [NDIG];
  digit_t             nib;
  logic               lead;
  logic               refresh_tick;
  logic               trigger;

  assign refresh_tick = auto_en && (refcnt_q == CNT_LAST);
  assign trigger      = start | refresh_tick;

  // Free-running refresh period; held at zero while auto-refresh is off.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      refcnt_q <= '0;
    end else if (!auto_en || refcnt_q == CNT_LAST) begin
      refcnt_q <= '0;
    end else begin
      refcnt_q <= refcnt_q + 1'b1;
    end
  end

  bcd_add3_stage #(.NDIG(NDIG)) u_add3 (
    .bcd_i (bcd_q),
    .bcd_o (bcd_adj)
  );

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    lzb_d   = lzb_q;
    ovfn_d  = ovfn_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          bin_d   = value;
          lzb_d   = lzb;
          bcd_d   = '0;
          iter_d  = '0;
          ovfn_d  = (value > MAX_VAL);
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
        iter_d         = iter_q + 5'd1;
        if (iter_q == 5'(DATA_W - 1)) begin
          state_d = LOAD;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan from the top digit down; blanking stops at the first nonzero digit,
  // and dig0 always shows so that zero reads as "0".
  always_comb begin
    lead = lzb_q;
    nib  = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      nib        = bcd_q[4*i +: 4];
      dig_new[i] = nib;
      if (ovfn_q) begin
        dig_new[i] = BLANK_CODE;
      end else if (lead && (i != 0) && (nib == 4'd0)) begin
        dig_new[i] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      lzb_q   <= 1'b0;
      ovfn_q  <= 1'b0;
      ovf_q   <= 1'b0;
      upd_q   <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        dig_q[i] <= BLANK_CODE;
      end
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      lzb_q   <= lzb_d;
      ovfn_q  <= ovfn_d;
      upd_q   <= (state_q == LOAD);
      if (state_q == LOAD) begin
        ovf_q <= ovfn_q;
        for (int i = 0; i < NDIG; i++) begin
          dig_q[i] <= dig_new[i];
        end
      end
    end
  end

  // Conversion datapath carries no reset; it is always initialised on accept.
  always_ff @(posedge clock) begin
    bin_q <= bin_d;
    bcd_q <= bcd_d;
  end

  assign busy = (state_q != IDLE);
  assign done = upd_q;
  assign upd  = upd_q;
  assign ovf  = ovf_q;
  assign dig0 = dig_q[0];
  assign dig1 = dig_q[1];
  assign dig2 = dig_q[2];
  assign dig3 = dig_q[3];
  assign dig4 = dig_q[4];
  assign dig5 = dig_q[5];
  assign dig6 = dig_q[6];

endmodule

// File: tb/tb_disp_bcd_ctrl.sv
// Directed bench for disp_bcd_ctrl with hand-computed expected digit patterns.
module tb_disp_bcd_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] value;
  logic        lzb;
  logic        auto_en;
  logic        busy, done, ovf, upd;
  logic [3:0]  dig0, dig1, dig2, dig3, dig4, dig5, dig6;
  logic [27:0] digs;

  int checks = 0;
  int errors = 0;
  int n;
  int cnt;

  always #5 clock = ~clock;

  assign digs = {dig6, dig5, dig4, dig3, dig2, dig1, dig0};

  disp_bcd_ctrl #(.REFRESH_DIV(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .value   (value),
    .lzb     (lzb),
    .auto_en (auto_en),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .upd     (upd),
    .dig0    (dig0),
    .dig1    (dig1),
    .dig2    (dig2),
    .dig3    (dig3),
    .dig4    (dig4),
    .dig5    (dig5),
    .dig6    (dig6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tk();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_upd(input int limit, output int cyc);
    cyc = 0;
    while (upd !== 1'b1 && cyc < limit) begin
      tk();
      cyc++;
    end
  endtask

  task automatic count_upd(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tk();
      if (upd === 1'b1) pulses++;
    end
  endtask

  task automatic conv(input string tag, input logic [23:0] v, input logic lz,
                      input logic [27:0] exp_d, input logic exp_ovf);
    int c;
    value = v;
    lzb   = lz;
    start = 1'b1;
    tk();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    wait_upd(40, c);
    chk({tag, "_latency"}, c + 1, 26);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_upd"}, busy, 1'b0);
    chk({tag, "_digits"}, digs, exp_d);
    chk({tag, "_ovf"}, ovf, exp_ovf);
    tk();
    chk({tag, "_upd_pulse"}, upd, 1'b0);
    chk({tag, "_hold"}, digs, exp_d);
  endtask

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    value   = '0;
    lzb     = 1'b0;
    auto_en = 1'b0;
    #2 reset_n = 1'b0;
    tk();
    tk();
    chk("rst_busy", busy, 1'b0);
    chk("rst_upd", upd, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_digits", digs, 28'hFFFFFFF);
    reset_n = 1'b1;
    tk();

    conv("v1234567", 24'd1234567, 1'b0, 28'h1234567, 1'b0);
    conv("v42_lzb", 24'd42, 1'b1, 28'hFFFFF42, 1'b0);
    conv("v0_lzb", 24'd0, 1'b1, 28'hFFFFFF0, 1'b0);
    conv("v9999999", 24'd9999999, 1'b0, 28'h9999999, 1'b0);
    conv("v10000000", 24'd10000000, 1'b0, 28'hFFFFFFF, 1'b1);
    conv("v100_nolzb", 24'd100, 1'b0, 28'h0000100, 1'b0);

    // start held high: back-to-back conversions every 26 cycles
    value = 24'd5;
    lzb   = 1'b0;
    start = 1'b1;
    tk();
    wait_upd(40, n);
    chk("held_first", n + 1, 26);
    tk();
    wait_upd(40, n);
    chk("held_period", n + 1, 26);
    chk("held_digits", digs, 28'h0000005);
    tk();
    start = 1'b0;
    wait_upd(40, n);
    chk("held_last", n + 1, 26);
    count_upd(40, cnt);
    chk("held_quiet", cnt, 0);

    // a start while busy is ignored
    value = 24'd1234567;
    start = 1'b1;
    tk();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tk();
    value = 24'd42;
    lzb   = 1'b1;
    start = 1'b1;
    tk();
    start = 1'b0;
    wait_upd(40, n);
    chk("busy_start_latency", n + 11, 26);
    chk("busy_start_digits", digs, 28'h1234567);
    count_upd(40, cnt);
    chk("busy_start_no_extra", cnt, 0);

    // auto refresh every 64 cycles
    value   = 24'd7;
    lzb     = 1'b0;
    auto_en = 1'b1;
    wait_upd(200, n);
    chk("auto_first_seen", (n < 200), 1'b1);
    chk("auto_digits7", digs, 28'h0000007);
    tk();
    value = 24'd8;
    tk();
    chk("auto_still7", digs, 28'h0000007);
    wait_upd(200, n);
    chk("auto_period", n + 2, 64);
    chk("auto_digits8", digs, 28'h0000008);
    tk();
    auto_en = 1'b0;
    count_upd(100, cnt);
    chk("auto_off_quiet", cnt, 0);

    // reset in the middle of a conversion
    value = 24'd1234567;
    lzb   = 1'b0;
    start = 1'b1;
    tk();
    start = 1'b0;
    for (int i = 0; i < 11; i++) tk();
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_upd", upd, 1'b0);
    chk("midrst_ovf", ovf, 1'b0);
    chk("midrst_digits", digs, 28'hFFFFFFF);
    tk();
    reset_n = 1'b1;
    count_upd(40, cnt);
    chk("midrst_no_upd", cnt, 0);
    chk("midrst_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
